// File: rtl/pc_sequencer.sv
// Stage-1 fetch controller: merges memory stalls, stage-2 redirects and a post-reset
// boot hold into PC stall/pc_sel, and tracks stage-2 validity and wrong-path kills.
module pc_sequencer #(
  parameter int unsigned BOOT_CYCLES = 2,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             icache_stall,
  input  logic             dcache_stall,
  input  logic             s2_branch_taken,
  input  logic             s2_jump,
  output logic             stall,
  output logic             pc_sel,
  output logic             s2_kill,
  output logic             s2_valid,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] redirect_count
);

  localparam int unsigned BOOT_W = 4;

  typedef enum logic [1:0] {
    BOOT    = 2'd0,
    RUN     = 2'd1,
    MEMWAIT = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [BOOT_W-1:0]  boot_q, boot_d;
  logic               valid_q, valid_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]   redir_cnt_q, redir_cnt_d;
  logic               mem_stall;
  logic               redirect;

  assign mem_stall      = icache_stall | dcache_stall;
  // A killed stage-2 slot has valid_q=0, so it can never redirect.
  assign redirect       = valid_q & (s2_branch_taken | s2_jump);
  assign s2_valid       = valid_q;
  assign stall_count    = stall_cnt_q;
  assign redirect_count = redir_cnt_q;

  // State register; reset is synchronous and overrides any in-flight stall or redirect.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= BOOT;
      boot_q      <= BOOT_W'(BOOT_CYCLES - 1);
      valid_q     <= 1'b0;
      stall_cnt_q <= '0;
      redir_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      boot_q      <= boot_d;
      valid_q     <= valid_d;
      stall_cnt_q <= stall_cnt_d;
      redir_cnt_q <= redir_cnt_d;
    end
  end

  // Next-state and combinational PC controls.
  always_comb begin
    state_d     = state_q;
    boot_d      = boot_q;
    valid_d     = valid_q;
    stall_cnt_d = stall_cnt_q;
    redir_cnt_d = redir_cnt_q;
    stall       = 1'b1;
    pc_sel      = 1'b0;
    s2_kill     = 1'b0;

    case (state_q)
      BOOT: begin
        if (boot_q == '0) begin
          state_d = RUN;
          valid_d = 1'b1;
        end else begin
          boot_d = boot_q - BOOT_W'(1);
        end
      end

      // MEMWAIT freezes stage 2; once mem_stall drops it behaves exactly as RUN.
      RUN, MEMWAIT: begin
        stall   = mem_stall;
        pc_sel  = redirect;
        s2_kill = ~valid_q;
        if (mem_stall) begin
          state_d     = MEMWAIT;
          stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end else begin
          state_d = RUN;
          valid_d = ~redirect;
          if (redirect) begin
            redir_cnt_d = redir_cnt_q + CNT_W'(1);
          end
        end
      end

      default: begin
        state_d = BOOT;
      end
    endcase
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: boot hold, redirects, kills, stalls and mid-stall reset.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        icache_stall, dcache_stall, s2_branch_taken, s2_jump;
  logic        stall, pc_sel, s2_kill, s2_valid;
  logic [31:0] stall_count, redirect_count;

  int n_tests = 0;
  int n_fail  = 0;

  pc_sequencer #(.BOOT_CYCLES(2), .CNT_W(32)) dut (
    .clk            (clk),
    .reset          (reset),
    .icache_stall   (icache_stall),
    .dcache_stall   (dcache_stall),
    .s2_branch_taken(s2_branch_taken),
    .s2_jump        (s2_jump),
    .stall          (stall),
    .pc_sel         (pc_sel),
    .s2_kill        (s2_kill),
    .s2_valid       (s2_valid),
    .stall_count    (stall_count),
    .redirect_count (redirect_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge, then settle away from it; inputs change here and outputs are sampled #1 later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ctl(input logic exp_stall, input logic exp_sel, input logic exp_kill,
                     input logic exp_valid, input string tag);
    #1;
    check({tag, ".stall"},    32'(stall),    32'(exp_stall));
    check({tag, ".pc_sel"},   32'(pc_sel),   32'(exp_sel));
    check({tag, ".s2_kill"},  32'(s2_kill),  32'(exp_kill));
    check({tag, ".s2_valid"}, 32'(s2_valid), 32'(exp_valid));
  endtask

  initial begin
    reset = 1'b1;
    icache_stall = 1'b0; dcache_stall = 1'b0; s2_branch_taken = 1'b0; s2_jump = 1'b0;

    // Reset values
    repeat (3) step();
    ctl(1'b1, 1'b0, 1'b0, 1'b0, "reset");
    check("reset.stall_count", stall_count, 32'd0);
    check("reset.redirect_count", redirect_count, 32'd0);

    // Boot hold: stall for exactly two cycles after release
    reset = 1'b0;
    ctl(1'b1, 1'b0, 1'b0, 1'b0, "boot0");
    step();
    ctl(1'b1, 1'b0, 1'b0, 1'b0, "boot1");
    step();
    ctl(1'b0, 1'b0, 1'b0, 1'b1, "run0");
    check("boot.stall_count", stall_count, 32'd0);

    // Taken branch
    s2_branch_taken = 1'b1;
    ctl(1'b0, 1'b1, 1'b0, 1'b1, "br");
    step();
    s2_branch_taken = 1'b0;
    ctl(1'b0, 1'b0, 1'b1, 1'b0, "br_kill");
    check("br.redirect_count", redirect_count, 32'd1);
    step();
    ctl(1'b0, 1'b0, 1'b0, 1'b1, "br_after");

    // Back-to-back jumps: second lands in the killed slot
    s2_jump = 1'b1;
    ctl(1'b0, 1'b1, 1'b0, 1'b1, "jmp1");
    step();
    ctl(1'b0, 1'b0, 1'b1, 1'b0, "jmp2");
    check("jmp2.redirect_count", redirect_count, 32'd2);
    step();
    s2_jump = 1'b0;
    ctl(1'b0, 1'b0, 1'b0, 1'b1, "jmp_after");
    check("jmp_after.redirect_count", redirect_count, 32'd2);

    // Redirect held under a 4-cycle dcache stall
    dcache_stall = 1'b1;
    s2_branch_taken = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ctl(1'b1, 1'b1, 1'b0, 1'b1, "stall_br");
      step();
    end
    dcache_stall = 1'b0;
    ctl(1'b0, 1'b1, 1'b0, 1'b1, "stall_br_accept");
    check("stall_br.stall_count", stall_count, 32'd4);
    check("stall_br.redirect_count_pre", redirect_count, 32'd2);
    step();
    s2_branch_taken = 1'b0;
    ctl(1'b0, 1'b0, 1'b1, 1'b0, "stall_br_kill");
    check("stall_br.redirect_count", redirect_count, 32'd3);
    step();
    ctl(1'b0, 1'b0, 1'b0, 1'b1, "stall_br_after");

    // Overlapping stalls: dcache 5 cycles, icache 3 cycles starting 2 later
    for (int i = 0; i < 5; i++) begin
      dcache_stall = 1'b1;
      icache_stall = (i >= 2);
      ctl(1'b1, 1'b0, 1'b0, 1'b1, "mixed");
      step();
    end
    dcache_stall = 1'b0;
    icache_stall = 1'b0;
    ctl(1'b0, 1'b0, 1'b0, 1'b1, "mixed_end");
    check("mixed.stall_count", stall_count, 32'd9);

    // Reset while in MEMWAIT with a redirect pending
    dcache_stall = 1'b1;
    s2_branch_taken = 1'b1;
    step();
    ctl(1'b1, 1'b1, 1'b0, 1'b1, "memwait");
    check("memwait.stall_count", stall_count, 32'd10);
    reset = 1'b1;
    step();
    ctl(1'b1, 1'b0, 1'b0, 1'b0, "midreset");
    check("midreset.stall_count", stall_count, 32'd0);
    check("midreset.redirect_count", redirect_count, 32'd0);
    reset = 1'b0;
    dcache_stall = 1'b0;
    step();
    ctl(1'b1, 1'b0, 1'b0, 1'b0, "reboot");
    check("reboot.redirect_count", redirect_count, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
